// File: rtl/tblink_rpc_clkctrl_if.sv
// Byte-stream bundle between the RPC demux/mux and the clock controller:
// t_* carries command/count bytes in, i_* carries response bytes out.
interface tblink_rpc_clkctrl_if;
  logic       t_valid;
  logic       t_ready;
  logic [7:0] t_dat;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_dat;

  modport master (
    output t_valid, t_dat, i_ready,
    input  t_ready, i_valid, i_dat
  );

  modport slave (
    input  t_valid, t_dat, i_ready,
    output t_ready, i_valid, i_dat
  );
endinterface

// File: rtl/tblink_rpc_clkctrl.sv
// tblink RPC clock controller: decodes byte commands and drives a gated,
// uclock/2 controlled clock with bounded advance, free-run, stop and capture.
module tblink_rpc_clkctrl #(
  parameter int DAT_BYTES = 4,
  parameter int CNT_BYTES = 2,
  parameter int CYC_BYTES = 4
) (
  input  logic                   uclock,
  input  logic                   reset_n,
  output logic                   cclock,
  output logic                   running,
  input  logic [8*DAT_BYTES-1:0] dat_i,
  tblink_rpc_clkctrl_if.slave    rpc
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_CNT    = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_STOPW  = 3'd4;
  localparam logic [2:0] ST_RSP    = 3'd5;

  localparam logic [1:0] OP_CAPTURE = 2'b00;
  localparam logic [1:0] OP_ADVANCE = 2'b01;
  localparam logic [1:0] OP_FREERUN = 2'b10;
  localparam logic [1:0] OP_STOP    = 2'b11;

  localparam int CNT_W     = (8 * CNT_BYTES > 6) ? 8 * CNT_BYTES : 6;
  localparam int CYC_W     = 8 * CYC_BYTES;
  localparam int RSP_BYTES = 1 + ((DAT_BYTES > CYC_BYTES) ? DAT_BYTES : CYC_BYTES);
  localparam int IDX_W     = $clog2(RSP_BYTES);
  localparam int CB_W      = (CNT_BYTES > 1) ? $clog2(CNT_BYTES) : 1;
  localparam int PAD_W     = 8 * (RSP_BYTES - 1);

  logic [2:0]       state;
  logic [7:0]       cmd;
  logic [CNT_W-1:0] cnt;
  logic [CB_W-1:0]  cnt_idx;
  logic             free_run;
  logic [CYC_W-1:0] cyc;
  logic             t_ready_q;
  logic             i_valid_q;
  logic [7:0]       i_dat_q;
  logic [IDX_W-1:0] rsp_idx;
  logic [IDX_W-1:0] rsp_last;
  logic [7:0]       rsp_buf [RSP_BYTES];

  logic [1:0]       op;
  logic [5:0]       short_n;
  logic             clk_en;
  logic             cclock_next;
  logic [CNT_W-1:0] cnt_merge;
  logic [7:0]       rsp_code;
  logic [PAD_W-1:0] dat_pad;
  logic [PAD_W-1:0] cyc_pad;
  logic             t_fire;
  logic             cnt_last;
  logic             rsp_done;

  assign op          = cmd[1:0];
  assign short_n     = cmd[7:2];
  assign clk_en      = (state == ST_RUN) || (state == ST_STOPW) || free_run;
  assign running     = clk_en;
  assign cclock_next = cclock ^ clk_en;
  assign dat_pad     = PAD_W'(dat_i);
  assign cyc_pad     = PAD_W'(cyc);
  assign t_fire      = rpc.t_valid && t_ready_q;
  assign cnt_last    = (cnt_idx == CB_W'(CNT_BYTES - 1));
  assign rsp_done    = (rsp_idx == rsp_last);

  assign rpc.t_ready = t_ready_q;
  assign rpc.i_valid = i_valid_q;
  assign rpc.i_dat   = i_dat_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_merge = cnt;
    cnt_merge[8*cnt_idx +: 8] = rpc.t_dat;
  end

  always_comb begin
    rsp_code = 8'h00;
    case (op)
      OP_CAPTURE: rsp_code = 8'h00;
      OP_ADVANCE: rsp_code = free_run ? 8'hFF : 8'h01;
      OP_FREERUN: rsp_code = 8'h02;
      OP_STOP:    rsp_code = 8'h03;
      default:    rsp_code = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge uclock or negedge reset_n) begin
    if (!reset_n) begin
      cclock <= 1'b0;
      cyc    <= '0;
    end else begin
      cclock <= cclock_next;
      if (clk_en && !cclock) cyc <= cyc + CYC_W'(1);
    end
  end

  // NOTE: the response buffer is plain storage that is always written before
  // it is read, so it carries no reset.
  always_ff @(posedge uclock) begin
    if (state == ST_DECODE) begin
      rsp_buf[0] <= rsp_code;
      for (int i = 1; i < RSP_BYTES; i++)
        rsp_buf[i] <= (op == OP_CAPTURE) ? dat_pad[8*(i-1) +: 8] : cyc_pad[8*(i-1) +: 8];
    end else if (state == ST_STOPW) begin
      for (int i = 1; i < RSP_BYTES; i++)
        rsp_buf[i] <= cyc_pad[8*(i-1) +: 8];
    end
  end

  always_ff @(posedge uclock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cmd       <= '0;
      cnt       <= '0;
      cnt_idx   <= '0;
      free_run  <= 1'b0;
      t_ready_q <= 1'b0;
      i_valid_q <= 1'b0;
      i_dat_q   <= '0;
      rsp_idx   <= '0;
      rsp_last  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (t_fire) begin
            cmd       <= rpc.t_dat;
            t_ready_q <= 1'b0;
            state     <= ST_DECODE;
          end else begin
            t_ready_q <= 1'b1;
          end
        end

        ST_DECODE: begin
          rsp_idx  <= '0;
          rsp_last <= '0;
          state    <= ST_RSP;
          case (op)
            OP_CAPTURE: rsp_last <= IDX_W'(DAT_BYTES);
            OP_ADVANCE: begin
              if (!free_run) begin
                if (short_n != 6'd0) begin
                  cnt   <= CNT_W'(short_n);
                  state <= ST_RUN;
                end else begin
                  cnt       <= '0;
                  cnt_idx   <= '0;
                  t_ready_q <= 1'b1;
                  state     <= ST_CNT;
                end
              end
            end
            OP_FREERUN: free_run <= 1'b1;
            OP_STOP: begin
              // If cclock is high after this edge, one more toggle parks it low.
              free_run <= 1'b0;
              rsp_last <= IDX_W'(CYC_BYTES);
              if (cclock_next) state <= ST_STOPW;
            end
            default: state <= ST_RSP;
          endcase
        end

        ST_CNT: begin
          if (t_fire) begin
            cnt     <= cnt_merge;
            cnt_idx <= cnt_idx + CB_W'(1);
            if (cnt_last) begin
              t_ready_q <= 1'b0;
              state     <= (cnt_merge == '0) ? ST_RSP : ST_RUN;
            end
          end
        end

        ST_RUN: begin
          // The count drops on each falling cclock; leaving on the last one ends low.
          if (cclock) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= ST_RSP;
          end
        end

        ST_STOPW: state <= ST_RSP;

        ST_RSP: begin
          if (!i_valid_q) begin
            i_valid_q <= 1'b1;
            i_dat_q   <= rsp_buf[rsp_idx];
          end else if (rpc.i_ready) begin
            if (rsp_done) begin
              i_valid_q <= 1'b0;
              i_dat_q   <= '0;
              t_ready_q <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              rsp_idx <= rsp_idx + IDX_W'(1);
              i_dat_q <= rsp_buf[rsp_idx + IDX_W'(1)];
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tblink_rpc_clkctrl.sv
// Directed bench for tblink_rpc_clkctrl; a second instance with a one-byte
// cycle counter runs in lockstep to expose counter wrap.
module tb_tblink_rpc_clkctrl;

  typedef logic [7:0] byte_q_t [$];

  typedef struct {
    int          nb;
    logic [23:0] cmd;
    logic [31:0] dat;
    int          nr;
    logic [39:0] rsp;
    int          rises;
    int          run;
  } vec_t;

  logic        uclock;
  logic        reset_n;
  logic        cclock, running;
  logic        cclock2, running2;
  logic [31:0] dat_i;

  tblink_rpc_clkctrl_if rpc ();
  tblink_rpc_clkctrl_if rpc2 ();

  assign rpc2.t_valid = rpc.t_valid;
  assign rpc2.t_dat   = rpc.t_dat;
  assign rpc2.i_ready = rpc.i_ready;

  tblink_rpc_clkctrl #(.DAT_BYTES(4), .CNT_BYTES(2), .CYC_BYTES(4)) dut (
    .uclock  (uclock),
    .reset_n (reset_n),
    .cclock  (cclock),
    .running (running),
    .dat_i   (dat_i),
    .rpc     (rpc)
  );

  tblink_rpc_clkctrl #(.DAT_BYTES(4), .CNT_BYTES(2), .CYC_BYTES(1)) dut2 (
    .uclock  (uclock),
    .reset_n (reset_n),
    .cclock  (cclock2),
    .running (running2),
    .dat_i   (dat_i),
    .rpc     (rpc2)
  );

  int      n_vec = 0;
  int      n_err = 0;
  int      rises = 0;
  int      rise_base = 0;
  int      run_cyc;
  byte_q_t got, got2;
  vec_t    vecs [9];

  initial begin
    uclock = 1'b0;
    forever #5 uclock = ~uclock;
  end

  always @(posedge cclock) rises = rises + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    rpc.t_valid = 1'b1;
    rpc.t_dat   = b;
    while (!rpc.t_ready && w < 2000) begin
      @(negedge uclock);
      w++;
    end
    check("t_ready_wait", rpc.t_ready, 1);
    check("dut2_t_ready", rpc2.t_ready, 1);
    @(posedge uclock);
    @(negedge uclock);
    rpc.t_valid = 1'b0;
  endtask

  task automatic send_cmd(input int nb, input logic [23:0] cmd);
    for (int i = 0; i < nb; i++) send_byte(cmd[8*i +: 8]);
  endtask

  task automatic collect(input int nr, input bit stall);
    logic [7:0] held;
    bit         stalled = 1'b0;
    int         cyc = 0;
    got.delete();
    got2.delete();
    run_cyc = 0;
    held = 8'h00;
    while (got.size() < nr && cyc < 2000) begin
      if (running) run_cyc++;
      rpc.i_ready = stall ? cyc[0] : 1'b1;
      if (rpc.i_valid) begin
        if (stalled) check("hold_i_dat", rpc.i_dat, held);
        if (rpc.i_ready) begin
          got.push_back(rpc.i_dat);
          stalled = 1'b0;
        end else begin
          held    = rpc.i_dat;
          stalled = 1'b1;
        end
      end
      if (rpc2.i_valid && rpc.i_ready) got2.push_back(rpc2.i_dat);
      @(negedge uclock);
      cyc++;
    end
    rpc.i_ready = 1'b1;
    check("i_valid_drop", rpc.i_valid, 0);
  endtask

  task automatic check_rsp(input string name, input byte_q_t q, input int n, input logic [39:0] exp);
    check({name, "_len"}, q.size(), n);
    for (int j = 0; j < n; j++)
      if (j < q.size()) check($sformatf("%s_b%0d", name, j), q[j], exp[8*j +: 8]);
  endtask

  initial begin
    int          snap;
    int          nr2;
    int          w;
    int          tot;
    logic [39:0] exp2;

    vecs[0] = '{1, 24'h000000, 32'hA1B2C3D4, 5, 40'hA1B2C3D400, 0, 0};
    vecs[1] = '{1, 24'h00000D, 32'h0,        1, 40'h01,         3, 6};
    vecs[2] = '{1, 24'h000003, 32'h0,        5, 40'h0000000303, 0, 0};
    vecs[3] = '{3, 24'h012C01, 32'h0,        1, 40'h01,         300, 600};
    vecs[4] = '{3, 24'h000001, 32'h0,        1, 40'h01,         0, 0};
    vecs[5] = '{1, 24'h000003, 32'h0,        5, 40'h0000012F03, 0, 0};
    vecs[6] = '{3, 24'h00D101, 32'h0,        1, 40'h01,         209, 418};
    vecs[7] = '{1, 24'h000003, 32'h0,        5, 40'h0000020003, 0, 0};
    vecs[8] = '{1, 24'h000000, 32'h00FF1234, 5, 40'h00FF123400, 0, 0};

    reset_n     = 1'b0;
    rpc.t_valid = 1'b0;
    rpc.t_dat   = 8'h00;
    rpc.i_ready = 1'b1;
    dat_i       = 32'h0;

    repeat (3) @(negedge uclock);
    check("rst_cclock",  cclock, 0);
    check("rst_running", running, 0);
    check("rst_t_ready", rpc.t_ready, 0);
    check("rst_i_valid", rpc.i_valid, 0);
    check("rst_i_dat",   rpc.i_dat, 0);
    reset_n = 1'b1;
    @(negedge uclock);
    check("t_ready_after_rst", rpc.t_ready, 1);

    // CAPTURE: first i_valid two edges after the accept edge
    dat_i = 32'hA1B2C3D4;
    send_cmd(1, 24'h000000);
    check("lat_e0_i_valid", rpc.i_valid, 0);
    @(negedge uclock);
    check("lat_e1_i_valid", rpc.i_valid, 0);
    @(negedge uclock);
    check("lat_e2_i_valid", rpc.i_valid, 1);
    collect(5, 1'b0);
    check_rsp("lat_cap", got, 5, 40'hA1B2C3D400);

    for (int i = 0; i < 9; i++) begin
      dat_i = vecs[i].dat;
      snap  = rises;
      send_cmd(vecs[i].nb, vecs[i].cmd);
      collect(vecs[i].nr, 1'b0);
      check_rsp($sformatf("v%0d", i), got, vecs[i].nr, vecs[i].rsp);
      check($sformatf("v%0d_rises", i), rises - snap, vecs[i].rises);
      check($sformatf("v%0d_run", i), run_cyc, vecs[i].run);
      check($sformatf("v%0d_cclock_low", i), cclock, 0);
      if (vecs[i].cmd[1:0] == 2'b11) begin
        nr2  = 2;
        exp2 = {24'h0, 8'(rises - rise_base), 8'h03};
      end else begin
        nr2  = vecs[i].nr;
        exp2 = vecs[i].rsp;
      end
      check_rsp($sformatf("v%0d_dut2", i), got2, nr2, exp2);
    end

    // CAPTURE with i_ready toggling every cycle
    dat_i = 32'h5A6B7C8D;
    send_cmd(1, 24'h000000);
    collect(5, 1'b1);
    check_rsp("stall_cap", got, 5, 40'h5A6B7C8D00);
    check_rsp("stall_cap_dut2", got2, 5, 40'h5A6B7C8D00);

    // Reset in the middle of ADVANCE n=10
    snap = rises;
    send_cmd(1, 24'h000029);
    w = 0;
    while (rises - snap < 3 && w < 100) begin
      @(negedge uclock);
      w++;
    end
    check("midadv_rises", rises - snap, 3);
    check("midadv_cclock_high", cclock, 1);
    #2 reset_n = 1'b0;
    rise_base = rises;
    #1;
    check("midadv_rst_cclock",  cclock, 0);
    check("midadv_rst_running", running, 0);
    check("midadv_rst_t_ready", rpc.t_ready, 0);
    check("midadv_rst_i_valid", rpc.i_valid, 0);
    @(negedge uclock);
    reset_n = 1'b1;
    @(negedge uclock);
    check("midadv_t_ready", rpc.t_ready, 1);
    send_cmd(1, 24'h000003);
    collect(5, 1'b0);
    check_rsp("midadv_stop", got, 5, 40'h0000000003);
    check_rsp("midadv_stop_dut2", got2, 2, 40'h0003);

    // FREE-RUN, rejected ADVANCE, then STOP with cclock high
    send_cmd(1, 24'h000002);
    collect(1, 1'b0);
    check_rsp("fr_start", got, 1, 40'h02);
    check_rsp("fr_start_dut2", got2, 1, 40'h02);
    check("fr_running", running, 1);
    send_cmd(1, 24'h00000D);
    collect(1, 1'b0);
    check_rsp("fr_adv_err", got, 1, 40'hFF);
    check_rsp("fr_adv_err_dut2", got2, 1, 40'hFF);
    check("fr_running_after_err", running, 1);
    w = 0;
    while (!cclock && w < 4) begin
      @(negedge uclock);
      w++;
    end
    check("fr_stop_at_high", cclock, 1);
    send_cmd(1, 24'h000003);
    collect(5, 1'b0);
    tot = rises - rise_base;
    check_rsp("fr_stop", got, 5, {tot, 8'h03});
    check_rsp("fr_stop_dut2", got2, 2, {24'h0, 8'(tot), 8'h03});
    check("fr_cclock_low", cclock, 0);
    check("fr_running_low", running, 0);
    check("fr_dut2_cclock_low", cclock2, 0);
    check("fr_dut2_running_low", running2, 0);
    snap = rises;
    repeat (4) @(negedge uclock);
    check("fr_stopped_no_rises", rises - snap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
